bf_tape_ctrl: RTL and testbench
===============================

Name: bf_tape_ctrl

Overview:
Data-side initiator for the CPU's tape RAM. It owns the data pointer and turns decoded data-path commands into RAM address/write-data traffic: add/sub, pointer moves, clear, and byte I/O via valid/ready handshakes. The tape RAM stores write_data at addr on every clock edge and reads combinationally. This block therefore always drives a write value: either the modified cell value or the current cell value written back unchanged.

Parameters:
DATA_W, 8, cell width; must match the RAM data width
ADDR_W, 6, pointer width; must match the RAM address width; tape length 2^ADDR_W

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge
cmd_op  in  3  0 NOP, 1 ADD, 2 SUB, 3 RIGHT, 4 LEFT, 5 OUT, 6 IN, 7 CLR
cmd_arg  in  DATA_W  repeat count: ADD/SUB amount; RIGHT/LEFT step, low ADDR_W bits only
mem_addr  out  ADDR_W  RAM address; equals the pointer register
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM combinational read data at mem_addr
cell_zero  out  1  mem_rdata == 0, combinational; consumed by the loop/branch unit
out_valid  out  1  output byte valid
out_data  out  DATA_W  output byte, registered
out_ready  in  1  output sink ready
in_valid  in  1  input byte valid
in_data  in  DATA_W  input byte
in_ready  out  1  block waiting for an input byte
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, OUT_WAIT, IN_WAIT, held in a 2-bit state register.
- Reset (async, rst=1):
  - state=IDLE, ptr=0, out_valid=0, out_data=0.
  - cmd_ready=0 while rst is asserted.
  - mem_wdata=mem_rdata during reset, so the RAM cell is preserved.
- Default in every cycle: mem_wdata = mem_rdata (write-back of the unchanged cell).
- cmd_ready = 1 in IDLE only. in_ready = 1 in IN_WAIT only. busy = (state != IDLE).
- IDLE, accepted command; single-cycle ops, block stays in IDLE:
  - ADD: mem_wdata = (mem_rdata + cmd_arg) mod 2^DATA_W, in the acceptance cycle.
  - SUB: mem_wdata = (mem_rdata - cmd_arg) mod 2^DATA_W; underflow wraps (0 - 1 = 2^DATA_W - 1).
  - CLR: mem_wdata = 0.
  - RIGHT: ptr <= (ptr + cmd_arg[ADDR_W-1:0]) mod 2^ADDR_W. The write in the acceptance cycle goes to the old address with unchanged data.
  - LEFT: ptr <= (ptr - cmd_arg[ADDR_W-1:0]) mod 2^ADDR_W; wraps 0 -> 2^ADDR_W - 1.
  - NOP: no state change.
  - An arg of 0 is legal for every op and is a no-op.
- IDLE, OUT accepted:
  - out_data <= mem_rdata, out_valid <= 1, state <= OUT_WAIT.
- OUT_WAIT:
  - out_valid and out_data are held stable until out_ready=1 at an edge.
  - On that edge: out_valid <= 0, state <= IDLE. Minimum OUT occupancy is 2 cycles.
- IDLE, IN accepted:
  - state <= IN_WAIT; the cell is untouched in the acceptance cycle.
- IN_WAIT:
  - While in_valid=0: write-back of the unchanged cell.
  - When in_valid=1 (in_ready is already 1): mem_wdata = in_data, state <= IDLE at that edge.
- Pointer is stable throughout OUT_WAIT/IN_WAIT.
- Commands presented while busy are not accepted; cmd_* must be held by the upstream.
- cmd_valid=0 in IDLE: pure write-back, nothing changes.
- Reset mid-operation:
  - Any pending OUT is dropped (out_valid falls asynchronously).
  - Any pending IN is abandoned.
  - ptr returns to 0. Tape contents are governed only by the RAM's own reset.
- Back-to-back single-cycle commands sustain one command per cycle.
- Each accepted command produces at most one RAM modification.

Test Plan:
- Reset, then ADD arg=5 and ADD arg=3 back-to-back -> cell[0]=8 after 2 edges; cmd_ready=1 throughout; cell_zero goes 1 -> 0.
- Cell[0]=0, SUB arg=1 -> cell[0]=0xFF; CLR -> cell[0]=0, cell_zero=1.
- Ptr=0: LEFT arg=1 -> mem_addr=63. Then RIGHT arg=2 -> mem_addr=1. RIGHT arg=0x41 uses the low 6 bits (1) -> mem_addr=2. Cells at every visited address are unchanged.
- Cell=0x2A, OUT with out_ready held 0 for 3 cycles then 1:
  - out_valid=1 and out_data=0x2A stable for 4 cycles; cmd_ready=0 and busy=1 during.
  - Returns to IDLE the cycle after the handshake edge.
- IN accepted, in_valid low 2 cycles, then in_valid=1 with in_data=0x7E -> cell=0x7E; in_ready falls, cmd_ready rises next cycle; no other cell written.
- OUT pending (out_valid=1), assert rst for 1 cycle -> out_valid=0 immediately, state IDLE, ptr=0; a subsequent ADD arg=1 works normally.

Source files
------------

// File: rtl/bf_tape_if.sv
// bf_tape_if: command, tape RAM and byte I/O signals of the tape data-path controller
interface bf_tape_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [DATA_W-1:0] cmd_arg;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              cell_zero;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              busy;
    modport master (
        input  cmd_valid, cmd_op, cmd_arg, mem_rdata, out_ready, in_valid, in_data,
        output cmd_ready, mem_addr, mem_wdata, cell_zero, out_valid, out_data, in_ready, busy
    );
    modport slave (
        output cmd_valid, cmd_op, cmd_arg, mem_rdata, out_ready, in_valid, in_data,
        input  cmd_ready, mem_addr, mem_wdata, cell_zero, out_valid, out_data, in_ready, busy
    );
endinterface

// File: rtl/bf_tape_ctrl.sv
// bf_tape_ctrl: owns the data pointer and turns data-path commands into tape RAM writes and byte I/O
module bf_tape_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input logic clk,
    input logic rst,
    bf_tape_if.master bus
);
    typedef enum logic [1:0] {IDLE, OUT_WAIT, IN_WAIT} state_t;
    localparam logic [2:0] OP_ADD = 3'd1, OP_SUB = 3'd2, OP_RIGHT = 3'd3, OP_LEFT = 3'd4,
                           OP_OUT = 3'd5, OP_IN = 3'd6, OP_CLR = 3'd7;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [DATA_W-1:0] wdata;
    logic              cmd_ready;
    logic              accept;
    assign cmd_ready = (state_q == IDLE) && !rst;
    assign accept    = bus.cmd_valid && cmd_ready;
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        wdata       = bus.mem_rdata;
        case (state_q)
            IDLE: if (accept) begin
                case (bus.cmd_op)
                    OP_ADD:   wdata = bus.mem_rdata + bus.cmd_arg;
                    OP_SUB:   wdata = bus.mem_rdata - bus.cmd_arg;
                    OP_CLR:   wdata = '0;
                    OP_RIGHT: ptr_d = ptr_q + bus.cmd_arg[ADDR_W-1:0];
                    OP_LEFT:  ptr_d = ptr_q - bus.cmd_arg[ADDR_W-1:0];
                    OP_OUT: begin
                        out_data_d  = bus.mem_rdata;
                        out_valid_d = 1'b1;
                        state_d     = OUT_WAIT;
                    end
                    OP_IN:    state_d = IN_WAIT;
                    default:  ;
                endcase
            end
            OUT_WAIT: if (bus.out_ready) begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
            IN_WAIT: if (bus.in_valid) begin
                wdata   = bus.in_data;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end
    // During reset the write path still mirrors the read data so the RAM cell survives.
    assign bus.mem_wdata = rst ? bus.mem_rdata : wdata;
    assign bus.mem_addr  = ptr_q;
    assign bus.cmd_ready = cmd_ready;
    assign bus.cell_zero = (bus.mem_rdata == '0);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.in_ready  = (state_q == IN_WAIT);
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_bf_tape_ctrl.sv
// tb_bf_tape_ctrl: directed stimulus with write/output scoreboards against a behavioural tape RAM
module tb_bf_tape_ctrl;
    localparam logic [2:0] ADD = 3'd1, SUB = 3'd2, RIGHT = 3'd3, LEFT = 3'd4,
                           OUT = 3'd5, IN = 3'd6, CLR = 3'd7;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [7:0]  ram [64];
    logic [13:0] wq [$];
    logic [7:0]  oq [$];
    bf_tape_if #(.DATA_W(8), .ADDR_W(6)) bus();
    bf_tape_ctrl #(.DATA_W(8), .ADDR_W(6)) dut (.clk(clk), .rst(rst), .bus(bus.master));
    always #5 clk = ~clk;
    assign bus.mem_rdata = ram[bus.mem_addr];
    always @(posedge clk) ram[bus.mem_addr] <= bus.mem_wdata;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic cmd(input logic [2:0] op, input logic [7:0] arg);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        while (!bus.cmd_ready && n < 20) begin
            step();
            n++;
        end
        chk("cmd_ready", 32'(bus.cmd_ready), 32'd1);
        step();
        bus.cmd_valid = 1'b0;
    endtask
    // Any edge that changes a cell must match the next expected {addr,data}; unexpected changes fail.
    always @(negedge clk) begin
        if (bus.mem_wdata !== bus.mem_rdata) begin
            if (wq.size() == 0) chk("unexpected_write", 32'({bus.mem_addr, bus.mem_wdata}), 32'h0);
            else chk("ram_write", 32'({bus.mem_addr, bus.mem_wdata}), 32'(wq.pop_front()));
        end
        if (bus.out_valid && bus.out_ready) begin
            if (oq.size() == 0) chk("unexpected_out", 32'(bus.out_data), 32'h0);
            else chk("out_data_hs", 32'(bus.out_data), 32'(oq.pop_front()));
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 8'h00;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_arg   = 8'h00;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        repeat (2) step();
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        #1;
        chk("cz_before_add", 32'(bus.cell_zero), 32'd1);
        wq.push_back({6'd0, 8'd5});
        wq.push_back({6'd0, 8'd8});
        cmd(ADD, 8'd5);
        cmd(ADD, 8'd3);
        chk("cell0_after_adds", 32'(ram[0]), 32'd8);
        chk("cz_after_add", 32'(bus.cell_zero), 32'd0);
        wq.push_back({6'd0, 8'h00});
        cmd(CLR, 8'd0);
        wq.push_back({6'd0, 8'hFF});
        cmd(SUB, 8'd1);
        chk("sub_wrap", 32'(ram[0]), 32'hFF);
        wq.push_back({6'd0, 8'h00});
        cmd(CLR, 8'd0);
        chk("cz_after_clr", 32'(bus.cell_zero), 32'd1);
        cmd(ADD, 8'd0);
        cmd(LEFT, 8'd1);
        chk("left_wrap", 32'(bus.mem_addr), 32'd63);
        cmd(RIGHT, 8'd2);
        chk("right_wrap", 32'(bus.mem_addr), 32'd1);
        cmd(RIGHT, 8'h41);
        chk("right_low_bits", 32'(bus.mem_addr), 32'd2);
        chk("cell63_untouched", 32'(ram[63]), 32'd0);
        wq.push_back({6'd2, 8'h2A});
        cmd(ADD, 8'h2A);
        oq.push_back(8'h2A);
        cmd(OUT, 8'd0);
        for (int i = 0; i < 4; i++) begin
            chk("out_valid_hold", 32'(bus.out_valid), 32'd1);
            chk("out_data_hold", 32'(bus.out_data), 32'h2A);
            chk("out_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            chk("out_busy", 32'(bus.busy), 32'd1);
            if (i == 3) bus.out_ready = 1'b1;
            step();
        end
        bus.out_ready = 1'b0;
        chk("out_done_valid", 32'(bus.out_valid), 32'd0);
        chk("out_done_ready", 32'(bus.cmd_ready), 32'd1);
        cmd(RIGHT, 8'd1);
        cmd(IN, 8'd0);
        for (int i = 0; i < 2; i++) begin
            chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
            chk("in_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            step();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h7E;
        wq.push_back({6'd3, 8'h7E});
        step();
        bus.in_valid = 1'b0;
        chk("in_ready_fall", 32'(bus.in_ready), 32'd0);
        chk("in_done_ready", 32'(bus.cmd_ready), 32'd1);
        chk("in_cell", 32'(ram[3]), 32'h7E);
        chk("in_addr", 32'(bus.mem_addr), 32'd3);
        cmd(OUT, 8'd0);
        chk("pend_out_valid", 32'(bus.out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_out_drop", 32'(bus.out_valid), 32'd0);
        chk("async_ptr", 32'(bus.mem_addr), 32'd0);
        chk("async_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        wq.push_back({6'd0, 8'd1});
        cmd(ADD, 8'd1);
        chk("post_rst_add", 32'(ram[0]), 32'd1);
        chk("post_rst_cell3", 32'(ram[3]), 32'h7E);
        step();
        chk("wq_drained", 32'(wq.size()), 32'd0);
        chk("oq_drained", 32'(oq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
